conv_window_buf: RTL and testbench

Parametrised sliding-window generator for the convolution layers. It accepts a raster-order pixel stream of `CHANNELS` samples per pixel and holds `K-1` full lines plus a `K×K` window register. It emits one flattened `K×K×CHANNELS` window per valid stride position. It sits between the image source (or the previous pooling stage) and the convolution MAC array, and replaces the fixed 28×28 / 5×5 / single-channel input buffer.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_line_buf.sv | 43 ++++
 rtl/conv_window_buf.sv | 128 ++++++++++++
 tb/tb_conv_window_buf.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the convolution window path: log2, window element
// indexing and the widths derived from the block parameters.
package conv_pkg;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic int pix_w(input int data_bits, input int channels);
        return data_bits * channels;
    endfunction

    function automatic int win_w(input int data_bits, input int channels, input int k);
        return k * k * channels * data_bits;
    endfunction

    function automatic int win_idx(input int r, input int c, input int ch,
                                   input int k, input int channels);
        return (r * k + c) * channels + ch;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Cascade of line delays: one WIDTH-deep circular RAM per stored line, all
// sharing a single pointer, so tap j yields the pixel j+1 lines above.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int LINES = 4,
    parameter int PW    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        shift_en,
    input  logic [PW-1:0]               din,
    output logic [LINES-1:0][PW-1:0]    taps
);
    localparam int AW = cnt_w(WIDTH);

    logic [AW-1:0]              ptr;
    logic [LINES:0][PW-1:0]     chain;

    assign chain[0] = din;
    assign taps     = chain[LINES:1];

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (shift_en)
            ptr <= (ptr == AW'(WIDTH - 1)) ? '0 : ptr + 1'b1;
    end

    for (genvar l = 0; l < LINES; l++) begin : g_line
        // Contents are deliberately left unreset; row gating hides stale data.
        logic [PW-1:0] mem [WIDTH];

        assign chain[l+1] = mem[ptr];

        always_ff @(posedge clk) begin
            if (shift_en)
                mem[ptr] <= chain[l];
        end
    end

endmodule

// File: rtl/conv_window_buf.sv
// Sliding KxK window generator over a raster pixel stream.
// Optional out_ready handshake is compiled in with CONV_WIN_BACKPRESSURE_EN.
module conv_window_buf
    import conv_pkg::*;
#(
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 28,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 1,
    parameter int K         = 5,
    parameter int STRIDE    = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [pix_w(DATA_BITS, CHANNELS)-1:0]        in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [win_w(DATA_BITS, CHANNELS, K)-1:0]     out_data,
    output logic                                         out_last,
    output logic                                         frame_done
);
    localparam int PW     = pix_w(DATA_BITS, CHANNELS);
    localparam int CW     = cnt_w(WIDTH);
    localparam int RW     = cnt_w(HEIGHT);
    localparam int SW     = cnt_w(STRIDE);
    localparam int LAST_C = K - 1 + ((WIDTH - K) / STRIDE) * STRIDE;
    localparam int LAST_R = K - 1 + ((HEIGHT - K) / STRIDE) * STRIDE;

    logic [CW-1:0]                  col;
    logic [RW-1:0]                  row;
    logic [SW-1:0]                  sc, sr;
    logic [K-1:0][K-1:0][PW-1:0]    win;
    logic [K-2:0][PW-1:0]           taps;
    logic [K-1:0][PW-1:0]           col_new;
    logic                           accept, eol, eof, close, is_last;

    assign accept  = in_valid && in_ready;
    assign eol     = (col == CW'(WIDTH - 1));
    assign eof     = eol && (row == RW'(HEIGHT - 1));
    assign close   = (row >= RW'(K - 1)) && (col >= CW'(K - 1)) && (sr == '0) && (sc == '0);
    assign is_last = (row == RW'(LAST_R)) && (col == CW'(LAST_C));

    conv_line_buf #(
        .WIDTH (WIDTH),
        .LINES (K - 1),
        .PW    (PW)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .din      (in_data),
        .taps     (taps)
    );

    // Incoming column: oldest line at the top, the live pixel at the bottom.
    assign col_new[K-1] = in_data;
    for (genvar j = 0; j < K - 1; j++) begin : g_col
        assign col_new[K-2-j] = taps[j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][K-1] <= col_new[r];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_r
        for (genvar c = 0; c < K; c++) begin : g_c
            for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
                assign out_data[win_idx(r, c, ch, K, CHANNELS)*DATA_BITS +: DATA_BITS] =
                    win[r][c][ch*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            sc         <= '0;
            sr         <= '0;
            frame_done <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            frame_done <= accept && eof;
            if (accept) begin
                col <= eol ? '0 : col + 1'b1;
                // Phases restart inside the leading K-1 margin so the first
                // full window always lands on phase 0.
                sc  <= (col < CW'(K - 1) || sc == SW'(STRIDE - 1)) ? '0 : sc + 1'b1;
                if (eol) begin
                    row <= eof ? '0 : row + 1'b1;
                    sr  <= (row < RW'(K - 1) || sr == SW'(STRIDE - 1)) ? '0 : sr + 1'b1;
                end
            end
`ifdef CONV_WIN_BACKPRESSURE_EN
            if (accept && close) begin
                out_valid <= 1'b1;
                out_last  <= is_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
`else
            out_valid <= accept && close;
            out_last  <= accept && close && is_last;
`endif
        end
    end

`ifdef CONV_WIN_BACKPRESSURE_EN
    assign in_ready = !out_valid || out_ready;
`else
    logic unused_out_ready;
    assign unused_out_ready = out_ready;
    assign in_ready         = 1'b1;
`endif

endmodule

// File: tb/tb_conv_window_buf.sv
// Directed bench for conv_window_buf: three parameterisations driven in turn,
// expected windows rebuilt from pixel coordinates.
module tb_conv_window_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // A: K=3, 5x5, stride 1, one channel
    logic        in_valid_a = 1'b0, in_ready_a, out_ready_a = 1'b1;
    logic [7:0]  in_data_a = '0;
    logic        out_valid_a, out_last_a, frame_done_a;
    logic [71:0] out_data_a;
    // B: K=3, 7x7, stride 2
    logic        in_valid_b = 1'b0, in_ready_b, out_ready_b = 1'b1;
    logic [7:0]  in_data_b = '0;
    logic        out_valid_b, out_last_b, frame_done_b;
    logic [71:0] out_data_b;
    // C: defaults with two channels
    logic         in_valid_c = 1'b0, in_ready_c, out_ready_c = 1'b1;
    logic [15:0]  in_data_c = '0;
    logic         out_valid_c, out_last_c, frame_done_c;
    logic [399:0] out_data_c;

    int wins;

    conv_window_buf #(.WIDTH(5), .HEIGHT(5), .DATA_BITS(8), .CHANNELS(1), .K(3), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_last(out_last_a), .frame_done(frame_done_a));

    conv_window_buf #(.WIDTH(7), .HEIGHT(7), .DATA_BITS(8), .CHANNELS(1), .K(3), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_last(out_last_b), .frame_done(frame_done_b));

    conv_window_buf #(.CHANNELS(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
        .out_last(out_last_c), .frame_done(frame_done_c));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_a(input int r, input int c);
        logic [71:0] v;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*8 +: 8] = 8'((r - 2 + i) * 5 + (c - 2 + j));
        return v;
    endfunction

    function automatic logic [71:0] exp_b(input int r, input int c);
        logic [71:0] v;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*8 +: 8] = 8'((r - 2 + i) * 7 + (c - 2 + j));
        return v;
    endfunction

    // Channel 0 carries frame/row, channel 1 frame/column.
    function automatic logic [15:0] pix_c(input bit f, input int r, input int c);
        return {f, 2'b01, 5'(c), f, 2'b00, 5'(r)};
    endfunction

    function automatic logic [399:0] exp_c(input bit f, input int r, input int c);
        logic [399:0] v;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                v[(i*5+j)*16 +: 16] = pix_c(f, r - 4 + i, c - 4 + j);
        return v;
    endfunction

    task automatic step_a(input bit v, input int r, input int c);
        bit cl;
        in_valid_a = v;
        in_data_a  = v ? 8'(r * 5 + c) : 8'hEE;
        @(posedge clk); @(negedge clk);
        cl = v && r >= 2 && c >= 2;
        chk("a_valid", out_valid_a, cl);
        chk("a_frame_done", frame_done_a, v && r == 4 && c == 4);
        if (cl) begin
            wins++;
            chk("a_data", out_data_a, exp_a(r, c));
            chk("a_last", out_last_a, r == 4 && c == 4);
        end
    endtask

`ifdef CONV_WIN_BACKPRESSURE_EN
    task automatic stall_a(input int r, input int c);
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_data_a   = 8'hEE;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            chk("a_stall_ready", in_ready_a, 1'b0);
            chk("a_stall_valid", out_valid_a, 1'b1);
            chk("a_stall_data", out_data_a, exp_a(r, c));
        end
        out_ready_a = 1'b1;
        in_valid_a  = 1'b0;
    endtask
`endif

    task automatic frame_a(input bit gaps, input bit stall);
        wins = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                if (gaps)
                    while ($urandom_range(0, 1) == 0) step_a(1'b0, r, c);
                step_a(1'b1, r, c);
                if (r == 2 && c == 2)
                    chk("a_first_window", out_data_a, 72'h0c0b0a070605020100);
`ifdef CONV_WIN_BACKPRESSURE_EN
                if (stall && r == 2 && c == 2) stall_a(r, c);
`endif
            end
        chk("a_window_count", wins, 9);
    endtask

    task automatic step_b(input int r, input int c);
        bit cl;
        in_valid_b = 1'b1;
        in_data_b  = 8'(r * 7 + c);
        @(posedge clk); @(negedge clk);
        cl = r >= 2 && c >= 2 && (r % 2) == 0 && (c % 2) == 0;
        chk("b_valid", out_valid_b, cl);
        chk("b_frame_done", frame_done_b, r == 6 && c == 6);
        if (cl) begin
            wins++;
            chk("b_data", out_data_b, exp_b(r, c));
            chk("b_last", out_last_b, r == 6 && c == 6);
        end
    endtask

    task automatic step_c(input bit f, input int r, input int c);
        bit cl;
        in_valid_c = 1'b1;
        in_data_c  = pix_c(f, r, c);
        @(posedge clk); @(negedge clk);
        cl = r >= 4 && c >= 4;
        chk("c_valid", out_valid_c, cl);
        chk("c_frame_done", frame_done_c, r == 27 && c == 27);
        if (cl) begin
            wins++;
            chk("c_data", out_data_c, exp_c(f, r, c));
            chk("c_last", out_last_c, r == 27 && c == 27);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid_a, 1'b0);
        chk("reset_out_last", out_last_a, 1'b0);
        chk("reset_frame_done", frame_done_a, 1'b0);
        chk("reset_out_data", out_data_a, 72'h0);
        chk("reset_in_ready", in_ready_a, 1'b1);
        rst = 1'b0;

        // Continuous frame (with a consumer stall when backpressure is built)
        frame_a(1'b0, 1'b1);
        // Back-to-back frame with random input gaps
        frame_a(1'b1, 1'b0);

        // Reset after 13 pixels, then a clean frame
        for (int p = 0; p < 13; p++) step_a(1'b1, p / 5, p % 5);
        rst        = 1'b1;
        in_valid_a = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_mid_out_valid", out_valid_a, 1'b0);
        chk("rst_mid_out_data", out_data_a, 72'h0);
        chk("rst_mid_frame_done", frame_done_a, 1'b0);
        rst = 1'b0;
        frame_a(1'b0, 1'b0);
        step_a(1'b0, 0, 0);

        // Stride 2
        wins = 0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) begin
                step_b(r, c);
                if (r == 2 && c == 2)
                    chk("b_first_window", out_data_b, 72'h100f0e090807020100);
            end
        in_valid_b = 1'b0;
        chk("b_window_count", wins, 9);

        // Two channels, two back-to-back frames
        for (int f = 0; f < 2; f++) begin
            wins = 0;
            for (int r = 0; r < 28; r++)
                for (int c = 0; c < 28; c++)
                    step_c(f[0], r, c);
            chk("c_window_count", wins, 576);
        end
        in_valid_c = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("c_idle_valid", out_valid_c, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
